// File: rtl/param_counter_if.sv
// Interface for param_counter: control inputs, terminal configuration and status outputs.
// The capture port pair exists only when PARAM_COUNTER_CAPTURE_EN is defined.
interface param_counter_if #(
    parameter int WIDTH = 16,
    parameter int PRE_W = 8
);
    logic             en;
    logic             up_dn;
    logic [1:0]       mode;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] limit;
    logic [PRE_W-1:0] prescale;
    logic [WIDTH-1:0] counter;
    logic             tc;
    logic             overflow;
    logic             done;
`ifdef PARAM_COUNTER_CAPTURE_EN
    logic             capture;
    logic [WIDTH-1:0] capture_value;

    modport master (
        output en, up_dn, mode, clear, load, load_value, limit, prescale, capture,
        input  counter, tc, overflow, done, capture_value
    );
    modport slave (
        input  en, up_dn, mode, clear, load, load_value, limit, prescale, capture,
        output counter, tc, overflow, done, capture_value
    );
`else
    modport master (
        output en, up_dn, mode, clear, load, load_value, limit, prescale,
        input  counter, tc, overflow, done
    );
    modport slave (
        input  en, up_dn, mode, clear, load, load_value, limit, prescale,
        output counter, tc, overflow, done
    );
`endif
endinterface

// File: rtl/param_counter.sv
// Prescaled up/down counter with wrap, saturate and one-shot terminal behaviour.
// Optional input capture register is compiled in with PARAM_COUNTER_CAPTURE_EN.
module param_counter #(
    parameter int WIDTH = 16,
    parameter int PRE_W = 8
) (
    input logic          clk,
    input logic          rst_n,
    param_counter_if.slave io_bus
);
    localparam logic [1:0] MODE_SAT  = 2'b01;
    localparam logic [1:0] MODE_ONCE = 2'b10;

    logic [WIDTH-1:0] r_cnt;
    logic [PRE_W-1:0] r_pre;
    logic             r_tc;
    logic             r_ovf;
    logic             r_done;

    logic             w_tick;
    logic             w_term;
    logic [WIDTH-1:0] w_step;
    logic             w_step_term;

    assign w_tick      = io_bus.en && (r_pre == io_bus.prescale);
    assign w_term      = io_bus.up_dn ? (r_cnt >= io_bus.limit) : (r_cnt == '0);
    assign w_step      = io_bus.up_dn ? r_cnt + 1'b1 : r_cnt - 1'b1;
    // Saturate mode flags tc on the step that lands on the terminal value.
    assign w_step_term = io_bus.up_dn ? (w_step >= io_bus.limit) : (w_step == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_pre  <= '0;
            r_tc   <= 1'b0;
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (io_bus.clear) begin
                r_cnt  <= '0;
                r_pre  <= '0;
                r_ovf  <= 1'b0;
                r_done <= 1'b0;
            end else if (io_bus.load) begin
                r_cnt  <= io_bus.load_value;
                r_pre  <= '0;
                r_done <= 1'b0;
            end else if (w_tick) begin
                r_pre <= '0;
                if (!r_done) begin
                    if (!w_term) begin
                        r_cnt <= w_step;
                        r_tc  <= (io_bus.mode == MODE_SAT) && w_step_term;
                    end else if (io_bus.mode == MODE_ONCE) begin
                        r_tc   <= 1'b1;
                        r_done <= 1'b1;
                    end else if (io_bus.mode != MODE_SAT) begin
                        r_cnt <= io_bus.up_dn ? '0 : io_bus.limit;
                        r_tc  <= 1'b1;
                        r_ovf <= 1'b1;
                    end
                end
            end else if (io_bus.en) begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end

    assign io_bus.counter  = r_cnt;
    assign io_bus.tc       = r_tc;
    assign io_bus.overflow = r_ovf;
    assign io_bus.done     = r_done;

`ifdef PARAM_COUNTER_CAPTURE_EN
    logic [WIDTH-1:0] r_cap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap <= '0;
        end else if (io_bus.capture) begin
            r_cap <= r_cnt;
        end
    end

    assign io_bus.capture_value = r_cap;
`endif
endmodule

// File: doc/param_counter.md
PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 Parameter WIDTH, default 16: counter width in bits, legal range 2..32.
REQ-002 Parameter PRE_W, default 8: prescaler width in bits, legal range 1..16.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  count enable; gates the prescaler and the counter.
REQ-006 up_dn  input  1  direction: 1 = up, 0 = down.
REQ-007 mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 reserved (behaves as wrap).
REQ-008 clear  input  1  synchronous clear.
REQ-009 load  input  1  synchronous load strobe.
REQ-010 load_value  input  WIDTH  value written to counter on load.
REQ-011 limit  input  WIDTH  terminal value for up counting and reload value for down wrap.
REQ-012 prescale  input  PRE_W  tick divider; counter advances once per (prescale+1) enabled cycles.
REQ-013 counter  output  WIDTH  registered count value.
REQ-014 tc  output  1  one-cycle terminal-count pulse.
REQ-015 overflow  output  1  sticky wrap flag.
REQ-016 done  output  1  one-shot expiry flag, held until clear, load or reset.

Function
REQ-017 The prescaler SHALL increment on each cycle with en=1, assert an internal tick when it equals prescale, and return to 0 on that same tick; prescale=0 SHALL give a tick on every enabled cycle.
REQ-018 With en=0, the prescaler, counter, tc and done SHALL hold; tc SHALL be 0.
REQ-019 Priority, highest first: clear, then load, then tick; clear SHALL zero counter, prescaler, overflow and done; load SHALL write load_value, zero the prescaler and clear done.
REQ-020 Terminal condition SHALL be counter >= limit when up_dn=1, and counter == 0 when up_dn=0.
REQ-021 On a tick with no terminal condition, counter SHALL step by +1 (up) or -1 (down) modulo 2^WIDTH.
REQ-022 Wrap mode on terminal tick: up SHALL go to 0, down SHALL go to limit; tc=1 and overflow set, both in the following cycle.
REQ-023 Saturate mode on terminal tick: counter SHALL hold; tc SHALL pulse only on the tick that first reaches the terminal value, and overflow SHALL remain unchanged.
REQ-024 One-shot mode on terminal tick: counter SHALL hold, tc SHALL pulse once and done SHALL set; while done=1 ticks SHALL be ignored.
REQ-025 Latency: counter, tc, overflow and done SHALL update one clock after the tick, clear or load that causes them; all outputs SHALL be registered.
REQ-026 A mode, up_dn, limit or prescale change SHALL take effect on the next tick, with no state reset.
REQ-027 limit=0 with up_dn=1 SHALL make every tick a terminal tick.
REQ-028 A load coinciding with a terminal tick SHALL win: no tc and no overflow update in that cycle.

Reset
REQ-029 While rst_n=0, counter, prescaler, tc, overflow, done (and capture when compiled in) SHALL be 0, independent of clk.
REQ-030 Reset asserted mid-count SHALL take effect immediately; the first tick after deassertion SHALL occur after (prescale+1) enabled cycles.

Configuration
REQ-031 Macro PARAM_COUNTER_CAPTURE_EN defined: add input capture (1 bit) and output capture_value (WIDTH bits); a capture=1 cycle SHALL latch counter into capture_value one clock later, regardless of en.
REQ-032 Same macro: a capture coinciding with a counter update SHALL latch the pre-update value.
REQ-033 Macro undefined: the capture port and register SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 WIDTH=16, prescale=0, mode=00, up, limit=16'h0003, en=1 from 0 -> counter 1,2,3,0; tc=1 on the 0 cycle; overflow=1 thereafter.
REQ-035 prescale=3, up, limit=FFFF -> counter increments every 4th enabled cycle; en=0 for 5 cycles mid-run -> counter and prescaler frozen.
REQ-036 Down, mode=01, load_value=2 -> 1,0,0,0; tc single pulse at first 0; overflow stays 0.
REQ-037 Mode=10, up, limit=5 -> stops at 5, done=1, tc once; load 0 -> done=0 and counting resumes.
REQ-038 clear and load asserted together at counter=7 -> counter=0, overflow=0; rst_n pulsed low mid-cycle -> all outputs 0 before the next edge.
REQ-039 With PARAM_COUNTER_CAPTURE_EN: capture at counter=9 on a tick -> capture_value=9 while counter=10.
